fop_seq: RTL and testbench
==========================

FOP_SEQ -- requirements
Module: fop_seq

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2: number of cycles fop_reset is held high per run, legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 16: width of run_len and cycle_cnt.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-006 stop  input  1  request to end the current run early; sampled in RESET and RUN.
REQ-007 run_len  input  CNT_W  enabled-cycle count for the run, latched on accepted start; 0 = free-run until stop.
REQ-008 fop_reset  output  1  drives the reset port of the downstream fop instance.
REQ-009 fop_enable  output  1  drives the enable port of the downstream fop instance.
REQ-010 busy  output  1  high in RESET, RUN and DONE.
REQ-011 done  output  1  one-cycle pulse marking the end of a completed run.
REQ-012 cycle_cnt  output  CNT_W  number of cycles fop_enable was high in the current or last run.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, RESET, RUN, DONE; all outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-014 IDLE: outputs low; start=1 and stop=0 SHALL latch run_len, clear cycle_cnt and enter RESET next cycle.
REQ-015 IDLE with start=1 and stop=1 together SHALL remain in IDLE (stop has priority).
REQ-016 RESET: fop_reset=1 and fop_enable=0 for exactly RST_CYCLES cycles, then RUN.
REQ-017 Stop during RESET SHALL return to IDLE next cycle, with fop_reset low and no done pulse.
REQ-018 RUN: fop_enable=1, fop_reset=0; cycle_cnt increments by 1 each RUN cycle, saturating at 2**CNT_W-1.
REQ-019 RUN with latched run_len=N>0 SHALL hold fop_enable high for exactly N cycles, then enter DONE.
REQ-020 RUN with latched run_len=0 SHALL stay in RUN until stop=1; it SHALL NOT time out on cycle_cnt saturation.
REQ-021 Stop during RUN SHALL enter DONE next cycle; the stop cycle itself SHALL still count as enabled.
REQ-022 Stop in the same cycle as the terminal count SHALL produce exactly one DONE entry and one done pulse.
REQ-023 DONE: fop_enable=0, done=1 for exactly one cycle, then IDLE; cycle_cnt SHALL hold its value until the next accepted start.
REQ-024 Start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 fop_reset and fop_enable SHALL never be high in the same cycle.
REQ-026 Changes to run_len after an accepted start SHALL have no effect on the current run.

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, fop_reset=0, fop_enable=0, busy=0, done=0 and cycle_cnt=0, at any time including mid-run.
REQ-028 After reset deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-029 The FSM state enum SHALL be defined in shared package fop_pkg, together with the RST_CYCLES and CNT_W defaults.
REQ-030 The saturating counter SHALL be a single sub-module fop_sat_cnt (CNT_W-wide, with clear, increment and max outputs); everything else is flat.

Verification
REQ-031 Reset, then start pulse with run_len=5 -> fop_reset high 2 cycles, fop_enable high 5 cycles, done pulse 1 cycle, cycle_cnt=5.
REQ-032 run_len=0, stop after 7 enabled cycles -> DONE next cycle, single done pulse, cycle_cnt=7 (stop cycle counted).
REQ-033 Stop during the second RESET cycle -> IDLE next cycle, fop_enable never high, done never high.
REQ-034 run_len=3 with stop on the third enabled cycle -> exactly one done pulse, cycle_cnt=3.
REQ-035 Reset asserted mid-RUN (run_len=10, after 4 cycles) -> all outputs 0 immediately; a following start with run_len=2 runs normally and ends with cycle_cnt=2.
REQ-036 Start pulses during RUN and DONE, plus run_len changed mid-run -> ignored; the run completes with the original latched length; an assertion checks fop_reset and fop_enable are never high together throughout.

Source files
------------

// File: rtl/fop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fop_pkg
//  Description : Shared definitions for the fop run sequencer: FSM state
//                encoding and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package fop_pkg;

    localparam int unsigned RST_CYCLES_DEF = 2;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fop_state_e;

endpackage : fop_pkg
`default_nettype wire

// File: rtl/fop_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : fop_sat_cnt
//  Description : CNT_W-wide up counter with synchronous clear that sticks at
//                its all-ones value instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module fop_sat_cnt
    import fop_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_max
);

    logic [CNT_W-1:0] r_count;
    logic             w_max;

    assign w_max   = &r_count;
    assign o_count = r_count;
    assign o_max   = w_max;

    // Counter register: clear wins over increment, increment stops at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !w_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : fop_sat_cnt
`default_nettype wire

// File: rtl/fop_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fop_seq
//  Description : Run sequencer for a downstream fop instance. On start it
//                holds the fop in reset for RST_CYCLES cycles, enables it for
//                run_len cycles (or until stop when run_len is zero), then
//                pulses done. All outputs come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module fop_seq
    import fop_pkg::*;
#(
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] run_len,
    output logic             fop_reset,
    output logic             fop_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    // Last value of the reset-phase counter before moving on to RUN
    localparam logic [7:0]       c_rst_last = 8'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};

    fop_state_e       r_state;
    fop_state_e       w_state_nxt;
    logic [7:0]       r_rst_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_fop_reset;
    logic             r_fop_enable;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_last;
    logic             w_inc;
    logic             w_at_max;
    logic [CNT_W-1:0] w_cnt;

    // Terminal count: this RUN cycle is the Nth enabled cycle of a bounded run
    assign w_last = (r_len != '0) && (w_cnt == (r_len - c_one));

    // Count every RUN cycle; no point requesting increments once saturated
    assign w_inc = (r_state == ST_RUN) && !w_at_max;

    fop_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_accept),
        .i_inc   (w_inc),
        .o_count (w_cnt),
        .o_max   (w_at_max)
    );

    // Next-state logic; stop takes priority over start in IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RESET;
                end
            end
            ST_RESET: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_rst_cnt == c_rst_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop || w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they are flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_fop_reset  <= 1'b0;
            r_fop_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fop_reset  <= (w_state_nxt == ST_RESET);
            r_fop_enable <= (w_state_nxt == ST_RUN);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

    // Reset-phase length counter, restarted whenever we are outside RESET
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_cnt <= '0;
        end else if (r_state != ST_RESET) begin
            r_rst_cnt <= '0;
        end else begin
            r_rst_cnt <= r_rst_cnt + 8'd1;
        end
    end

    // Run length captured on an accepted start and frozen for the whole run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len <= '0;
        end else if (w_accept) begin
            r_len <= run_len;
        end
    end

    assign fop_reset  = r_fop_reset;
    assign fop_enable = r_fop_enable;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cycle_cnt  = w_cnt;

endmodule : fop_seq
`default_nettype wire

// File: tb/tb_fop_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fop_seq
//  Description : Directed self-checking bench for fop_seq with a run-result
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fop_seq;

    localparam int CNT_W = 16;

    logic             tb_clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] run_len;
    logic             fop_reset;
    logic             fop_enable;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    int checks = 0;
    int errors = 0;
    int n_en   = 0;
    int n_rs   = 0;
    int n_done = 0;

    typedef struct {
        int cnt;
        int en;
        int rs;
    } exp_t;

    exp_t sb[$];

    fop_seq #(
        .RST_CYCLES (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (tb_clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .run_len    (run_len),
        .fop_reset  (fop_reset),
        .fop_enable (fop_enable),
        .busy       (busy),
        .done       (done),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 tb_clk = ~tb_clk;

    // Per-cycle activity counters and the reset/enable exclusivity check
    always @(negedge tb_clk) begin
        if (fop_enable) n_en++;
        if (fop_reset)  n_rs++;
        if (done)       n_done++;
        checks++;
        assert (!(fop_reset && fop_enable)) else begin
            errors++;
            $error("FAIL excl: observed fop_reset=%0b fop_enable=%0b expected not both high",
                   fop_reset, fop_enable);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; ends on the negedge of the first RESET cycle
    task automatic begin_run(input int len, input string tag);
        @(posedge tb_clk); #1;
        run_len = CNT_W'(len);
        start   = 1'b1;
        n_en    = 0;
        n_rs    = 0;
        n_done  = 0;
        @(posedge tb_clk); #1;
        start = 1'b0;
        @(negedge tb_clk);
        check({tag, "_first_rst"}, {29'd0, fop_reset, busy, fop_enable}, 32'b110);
    endtask

    task automatic wait_enable(input string tag);
        int i;
        i = 0;
        while (!fop_enable && i < 20) begin
            @(negedge tb_clk);
            i++;
        end
        check({tag, "_en_seen"}, {31'd0, fop_enable}, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (!done && i < 100) begin
            @(negedge tb_clk);
            i++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_done_no_en"}, {31'd0, fop_enable}, 32'd0);
    endtask

    task automatic finish_run(input string tag);
        exp_t e;
        repeat (3) @(negedge tb_clk);
        check({tag, "_sb_size"}, sb.size(), 32'd1);
        e = sb.pop_front();
        check({tag, "_cycle_cnt"}, {16'd0, cycle_cnt}, e.cnt);
        check({tag, "_en_cycles"}, n_en, e.en);
        check({tag, "_rst_cycles"}, n_rs, e.rs);
        check({tag, "_done_pulses"}, n_done, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        run_len = '0;
        repeat (2) @(negedge tb_clk);
        check("reset_outs", {28'd0, fop_reset, fop_enable, busy, done}, 32'd0);
        check("reset_cnt", {16'd0, cycle_cnt}, 32'd0);
        reset = 1'b0;

        // Basic bounded run
        sb.push_back('{cnt: 5, en: 5, rs: 2});
        begin_run(5, "t_len5");
        wait_done("t_len5");
        finish_run("t_len5");

        // Free run ended by stop on the 7th enabled cycle
        sb.push_back('{cnt: 7, en: 7, rs: 2});
        begin_run(0, "t_free");
        wait_enable("t_free");
        repeat (6) @(negedge tb_clk);
        stop = 1'b1;
        @(posedge tb_clk); #1;
        stop = 1'b0;
        @(negedge tb_clk);
        check("t_free_done_next", {31'd0, done}, 32'd1);
        wait_done("t_free");
        finish_run("t_free");

        // Stop during the second RESET cycle aborts silently
        begin_run(4, "t_abort");
        @(negedge tb_clk);
        stop = 1'b1;
        @(posedge tb_clk); #1;
        stop = 1'b0;
        @(negedge tb_clk);
        check("t_abort_idle", {30'd0, fop_reset, busy}, 32'd0);
        repeat (4) @(negedge tb_clk);
        check("t_abort_en", n_en, 32'd0);
        check("t_abort_done", n_done, 32'd0);
        check("t_abort_cnt", {16'd0, cycle_cnt}, 32'd0);

        // Start and stop together in IDLE: stop wins
        @(posedge tb_clk); #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge tb_clk);
        check("t_startstop_idle", {31'd0, busy}, 32'd0);

        // Stop coincides with terminal count
        sb.push_back('{cnt: 3, en: 3, rs: 2});
        begin_run(3, "t_coinc");
        wait_enable("t_coinc");
        repeat (2) @(negedge tb_clk);
        stop = 1'b1;
        @(posedge tb_clk); #1;
        stop = 1'b0;
        wait_done("t_coinc");
        finish_run("t_coinc");

        // Asynchronous reset in the middle of a run
        begin_run(10, "t_midrst");
        wait_enable("t_midrst");
        repeat (3) @(negedge tb_clk);
        reset = 1'b1;
        #1;
        check("t_midrst_outs", {28'd0, fop_reset, fop_enable, busy, done}, 32'd0);
        check("t_midrst_cnt", {16'd0, cycle_cnt}, 32'd0);
        @(negedge tb_clk);
        reset = 1'b0;
        sb.push_back('{cnt: 2, en: 2, rs: 2});
        begin_run(2, "t_after_rst");
        wait_done("t_after_rst");
        finish_run("t_after_rst");

        // Starts during RUN/DONE and run_len changes mid-run are ignored
        sb.push_back('{cnt: 6, en: 6, rs: 2});
        begin_run(6, "t_ignore");
        wait_enable("t_ignore");
        @(negedge tb_clk);
        run_len = CNT_W'(2);
        start   = 1'b1;
        @(negedge tb_clk);
        start   = 1'b0;
        run_len = CNT_W'(9);
        wait_done("t_ignore");
        start = 1'b1;
        @(negedge tb_clk);
        start = 1'b0;
        check("t_ignore_no_queue", {31'd0, busy}, 32'd0);
        finish_run("t_ignore");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fop_seq
`default_nettype wire
